// File: rtl/memctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_pkg
// Brief    : Shared types and constants for the memory access controller.
// Revision : 1.0 - initial release
// ============================================================================
package memctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Kind of access currently owning the memory port
    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } kind_t;

    localparam logic [31:0] HALT_OPCODE           = 32'hFFFF_FFFF;
    localparam int          c_default_mem_latency = 2;
    localparam int          c_cnt_width           = 4;

endpackage
`default_nettype wire

// File: rtl/memctrl_latency_counter.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_latency_counter
// Brief    : 4-bit ACCESS-cycle counter with clear, enable and a terminal
//            count flag raised when the count equals MEM_LATENCY.
// Revision : 1.0 - initial release
// ============================================================================
module memctrl_latency_counter
    import memctrl_pkg::*;
#(
    parameter int MEM_LATENCY = c_default_mem_latency
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [c_cnt_width-1:0] c_terminal = c_cnt_width'(MEM_LATENCY);
    localparam logic [c_cnt_width-1:0] c_one      = c_cnt_width'(1);

    logic [c_cnt_width-1:0] r_count;

    // Clear has priority over counting so completion always leaves zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_tc = (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_controller
// Brief    : Single master in front of MAIN_MEMORY. Arbitrates data
//            write > data read > instruction fetch, runs one access at a
//            time terminated by ACK or MEM_LATENCY, latches IR / RDATA and
//            raises a sticky halt on the halt opcode.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_controller
    import memctrl_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int MEM_LATENCY   = c_default_mem_latency
)
(
    input  logic                     MEMCTRL_CLOCK_50,
    input  logic                     MEMCTRL_RESET_InHigh,
    input  logic                     MEMCTRL_IF_REQ_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_IF_PC_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMCTRL_IF_IR_OutBUS,
    output logic                     MEMCTRL_IF_DONE_Out,
    input  logic                     MEMCTRL_D_RD_In,
    input  logic                     MEMCTRL_D_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_D_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_D_WDATA_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMCTRL_D_RDATA_OutBUS,
    output logic                     MEMCTRL_D_DONE_Out,
    output logic                     MEMCTRL_BUSY_Out,
    output logic                     MEMCTRL_HALT_Out,
    output logic                     MEMCTRL_ALIGN_ERR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEMCTRL_MEM_ADDRESS_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEMCTRL_MEM_data_OutBUS,
    output logic                     MEMCTRL_MEM_RD_Out,
    output logic                     MEMCTRL_MEM_WR_Out,
    input  logic [DATAWIDTH_BUS-1:0] MEMCTRL_MEM_data_InBUS,
    input  logic                     MEMCTRL_MEM_ACK_In
);

    state_t                   r_state;
    kind_t                    r_kind;
    logic [DATAWIDTH_BUS-1:0] r_mem_addr;
    logic [DATAWIDTH_BUS-1:0] r_mem_data;
    logic                     r_mem_rd;
    logic                     r_mem_wr;
    logic [DATAWIDTH_BUS-1:0] r_ir;
    logic [DATAWIDTH_BUS-1:0] r_rdata;
    logic                     r_if_done;
    logic                     r_d_done;
    logic                     r_halt;
    logic                     r_align_err;

    logic                     w_sel_valid;
    kind_t                    w_sel_kind;
    logic [DATAWIDTH_BUS-1:0] w_sel_addr;
    logic                     w_aligned;
    logic                     w_access_end;
    logic                     w_cnt_en;
    logic                     w_cnt_tc;

    // Fixed-priority request selection: write, then read, then fetch
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_kind  = KIND_FETCH;
        w_sel_addr  = MEMCTRL_IF_PC_InBUS;
        if (MEMCTRL_D_WR_In) begin
            w_sel_kind = KIND_STORE;
            w_sel_addr = MEMCTRL_D_ADDRESS_InBUS;
        end else if (MEMCTRL_D_RD_In) begin
            w_sel_kind = KIND_LOAD;
            w_sel_addr = MEMCTRL_D_ADDRESS_InBUS;
        end else if (!MEMCTRL_IF_REQ_In) begin
            w_sel_valid = 1'b0;
        end
    end

    assign w_aligned    = (w_sel_addr[1:0] == 2'b00);
    assign w_access_end = (r_state == ST_ACCESS) && (MEMCTRL_MEM_ACK_In || w_cnt_tc);
    // Counter steps to 1 on the accepting edge so the first ACCESS cycle reads 1
    assign w_cnt_en     = ((r_state == ST_IDLE) && w_sel_valid && w_aligned) ||
                          ((r_state == ST_ACCESS) && !w_access_end);

    memctrl_latency_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_latency_counter (
        .clk   (MEMCTRL_CLOCK_50),
        .rst   (MEMCTRL_RESET_InHigh),
        .i_clr (w_access_end),
        .i_en  (w_cnt_en),
        .o_tc  (w_cnt_tc)
    );

    // Main sequencer with registered memory strobes, results and pulses
    always_ff @(posedge MEMCTRL_CLOCK_50 or posedge MEMCTRL_RESET_InHigh) begin
        if (MEMCTRL_RESET_InHigh) begin
            r_state     <= ST_IDLE;
            r_kind      <= KIND_FETCH;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_ir        <= '0;
            r_rdata     <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_halt      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_align_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        if (!w_aligned) begin
                            r_align_err <= 1'b1;
                        end else begin
                            r_kind     <= w_sel_kind;
                            r_mem_addr <= w_sel_addr;
                            if (w_sel_kind == KIND_STORE) begin
                                r_mem_data <= MEMCTRL_D_WDATA_InBUS;
                            end
                            r_mem_rd   <= (w_sel_kind != KIND_STORE);
                            r_mem_wr   <= (w_sel_kind == KIND_STORE);
                            r_state    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_access_end) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= ST_DONE;
                        case (r_kind)
                            KIND_FETCH: begin
                                r_ir      <= MEMCTRL_MEM_data_InBUS;
                                r_if_done <= 1'b1;
                                if (MEMCTRL_MEM_data_InBUS == DATAWIDTH_BUS'(HALT_OPCODE)) begin
                                    r_halt <= 1'b1;
                                end
                            end
                            KIND_LOAD: begin
                                r_rdata  <= MEMCTRL_MEM_data_InBUS;
                                r_d_done <= 1'b1;
                            end
                            KIND_STORE: begin
                                r_d_done <= 1'b1;
                            end
                            default: begin
                                r_d_done <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    r_state <= r_halt ? ST_HALTED : ST_IDLE;
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign MEMCTRL_IF_IR_OutBUS       = r_ir;
    assign MEMCTRL_IF_DONE_Out        = r_if_done;
    assign MEMCTRL_D_RDATA_OutBUS     = r_rdata;
    assign MEMCTRL_D_DONE_Out         = r_d_done;
    assign MEMCTRL_BUSY_Out           = (r_state != ST_IDLE);
    assign MEMCTRL_HALT_Out           = r_halt;
    assign MEMCTRL_ALIGN_ERR_Out      = r_align_err;
    assign MEMCTRL_MEM_ADDRESS_OutBUS = r_mem_addr;
    assign MEMCTRL_MEM_data_OutBUS    = r_mem_data;
    assign MEMCTRL_MEM_RD_Out         = r_mem_rd;
    assign MEMCTRL_MEM_WR_Out         = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_controller
// Brief    : Self-checking bench: vector table, hand sequences for
//            arbitration and reset-in-ACCESS, and random single operations
//            checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memory_access_controller;

    localparam int LAT = 2;
    localparam int WIN = 8;

    typedef struct {
        int          rd;
        int          wr;
        int          done_cyc;
        int          ifd;
        int          dd;
        int          align;
        int          busy;
        logic        halt;
        logic [31:0] ir;
        logic [31:0] rdata;
        logic [31:0] saddr;
        logic [31:0] sdata;
    } exp_t;

    typedef struct {
        logic        ifr;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memval;
        int          ack_cyc;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_rd, d_wr, ack;
    logic [31:0] pc, daddr, wdata;
    logic [31:0] ir, rdata, mem_addr, mem_dout, mem_din;
    logic        if_done, d_done, busy, halt, align, mem_rd, mem_wr;
    logic [31:0] tb_mem [0:255];

    int total = 0;
    int bad   = 0;

    // observation record of the last operation
    int          ob_rd, ob_wr, ob_done_cyc, ob_ifd, ob_dd, ob_align, ob_busy;
    logic [31:0] ob_saddr, ob_sdata;
    logic        ob_halt_done, ob_halt_end;

    // model state
    logic [31:0] m_ir, m_rdata;
    logic        m_halted;

    vec_t vecs [13];

    always #5 clk = ~clk;

    assign mem_din = tb_mem[mem_addr[9:2]];

    memory_access_controller #(
        .DATAWIDTH_BUS (32),
        .MEM_LATENCY   (LAT)
    ) dut (
        .MEMCTRL_CLOCK_50           (clk),
        .MEMCTRL_RESET_InHigh       (rst),
        .MEMCTRL_IF_REQ_In          (if_req),
        .MEMCTRL_IF_PC_InBUS        (pc),
        .MEMCTRL_IF_IR_OutBUS       (ir),
        .MEMCTRL_IF_DONE_Out        (if_done),
        .MEMCTRL_D_RD_In            (d_rd),
        .MEMCTRL_D_WR_In            (d_wr),
        .MEMCTRL_D_ADDRESS_InBUS    (daddr),
        .MEMCTRL_D_WDATA_InBUS      (wdata),
        .MEMCTRL_D_RDATA_OutBUS     (rdata),
        .MEMCTRL_D_DONE_Out         (d_done),
        .MEMCTRL_BUSY_Out           (busy),
        .MEMCTRL_HALT_Out           (halt),
        .MEMCTRL_ALIGN_ERR_Out      (align),
        .MEMCTRL_MEM_ADDRESS_OutBUS (mem_addr),
        .MEMCTRL_MEM_data_OutBUS    (mem_dout),
        .MEMCTRL_MEM_RD_Out         (mem_rd),
        .MEMCTRL_MEM_WR_Out         (mem_wr),
        .MEMCTRL_MEM_data_InBUS     (mem_din),
        .MEMCTRL_MEM_ACK_In         (ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one request from IDLE/HALTED and observe a fixed window of cycles
    task automatic run_op(input logic ifr, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_cyc);
        logic seen;
        seen = 1'b0;
        if_req = ifr; d_rd = rd; d_wr = wr; pc = addr; daddr = addr; wdata = wd; ack = 1'b0;
        ob_rd = 0; ob_wr = 0; ob_done_cyc = 0; ob_ifd = 0; ob_dd = 0; ob_align = 0; ob_busy = 0;
        ob_saddr = '0; ob_sdata = '0; ob_halt_done = 1'b0;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (mem_rd) ob_rd++;
            if (mem_wr) ob_wr++;
            if ((mem_rd || mem_wr) && !seen) begin
                ob_saddr = mem_addr; ob_sdata = mem_dout; seen = 1'b1;
            end
            if (if_done) ob_ifd++;
            if (d_done) ob_dd++;
            if ((if_done || d_done) && ob_done_cyc == 0) begin
                ob_done_cyc = c; ob_halt_done = halt;
            end
            if (align) ob_align++;
            if (busy) ob_busy++;
            if (if_done || d_done || align) begin
                if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
            end
            ack = (c == ack_cyc);
        end
        ob_halt_end = halt;
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; ack = 1'b0;
    endtask

    task automatic compare_obs(input string tag, input exp_t e);
        chk({tag, "_rd_cycles"}, ob_rd, e.rd);
        chk({tag, "_wr_cycles"}, ob_wr, e.wr);
        chk({tag, "_done_cycle"}, ob_done_cyc, e.done_cyc);
        chk({tag, "_if_done_cnt"}, ob_ifd, e.ifd);
        chk({tag, "_d_done_cnt"}, ob_dd, e.dd);
        chk({tag, "_align_cnt"}, ob_align, e.align);
        chk({tag, "_busy_cycles"}, ob_busy, e.busy);
        chk({tag, "_halt"}, ob_halt_end, e.halt);
        if (e.done_cyc != 0) chk({tag, "_halt_at_done"}, ob_halt_done, e.halt);
        chk({tag, "_ir"}, ir, e.ir);
        chk({tag, "_rdata"}, rdata, e.rdata);
        chk({tag, "_mem_addr"}, ob_saddr, e.saddr);
        if (e.wr != 0) chk({tag, "_mem_wdata"}, ob_sdata, e.sdata);
    endtask

    // Transaction-level reference: what one request does from the current state
    task automatic model_op(input logic ifr, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] memval, input int ack_cyc, output exp_t e);
        int k;
        e = '{0, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        if (m_halted) begin
            e.busy = WIN;
            e.halt = 1'b1;
        end else if (addr[1:0] != 2'b00) begin
            e.align = 1;
        end else if (wr || rd || ifr) begin
            k = (ack_cyc >= 1 && ack_cyc <= LAT) ? ack_cyc : LAT;
            e.done_cyc = k + 1;
            e.busy     = k + 1;
            e.saddr    = addr;
            if (wr) begin
                e.wr = k; e.dd = 1; e.sdata = wd;
            end else if (rd) begin
                e.rd = k; e.dd = 1; m_rdata = memval;
            end else begin
                e.rd = k; e.ifd = 1; m_ir = memval;
                if (memval == 32'hFFFF_FFFF) begin
                    m_halted = 1'b1; e.halt = 1'b1; e.busy = WIN;
                end
            end
        end
        e.ir    = m_ir;
        e.rdata = m_rdata;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_flags"}, {21'd0, mem_rd, mem_wr, if_done, d_done, busy, halt, align, 4'd0},
            32'd0);
        chk({tag, "_ir"}, ir, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_data"}, mem_dout, 32'h0);
        m_ir = '0; m_rdata = '0; m_halted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a1, a2;
        int          naddr, dcyc, icyc, cnt;
        exp_t        e;
        logic        ifr, rd, wr, was_halted;
        logic [31:0] addr, wd, mv;
        int          ackc;

        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        rst = 1'b1; if_req = 0; d_rd = 0; d_wr = 0; ack = 0; pc = 0; daddr = 0; wdata = 0;
        m_ir = '0; m_rdata = '0; m_halted = 1'b0;
        @(negedge clk);
        do_reset("reset_init");

        //          ifr rd wr addr          wdata         memval        ack   rd wr dc ifd dd al bsy halt ir            rdata         saddr         sdata
        vecs[0]  = '{1, 0, 0, 32'h800, 32'h0,        32'h82102000, 0, '{2, 0, 3, 1, 0, 0, 3, 1'b0, 32'h82102000, 32'h0,        32'h800, 32'h0}};
        vecs[1]  = '{1, 0, 0, 32'h804, 32'h0,        32'h11112222, 1, '{1, 0, 2, 1, 0, 0, 2, 1'b0, 32'h11112222, 32'h0,        32'h804, 32'h0}};
        vecs[2]  = '{0, 1, 0, 32'h900, 32'h0,        32'h12345678, 2, '{2, 0, 3, 0, 1, 0, 3, 1'b0, 32'h11112222, 32'h12345678, 32'h900, 32'h0}};
        vecs[3]  = '{0, 0, 1, 32'h904, 32'hCAFEF00D, 32'h0,        0, '{0, 2, 3, 0, 1, 0, 3, 1'b0, 32'h11112222, 32'h12345678, 32'h904, 32'hCAFEF00D}};
        vecs[4]  = '{0, 1, 1, 32'h908, 32'hA5A5A5A5, 32'h77,       1, '{0, 1, 2, 0, 1, 0, 2, 1'b0, 32'h11112222, 32'h12345678, 32'h908, 32'hA5A5A5A5}};
        vecs[5]  = '{0, 0, 1, 32'h802, 32'h1234,     32'h0,        0, '{0, 0, 0, 0, 0, 1, 0, 1'b0, 32'h11112222, 32'h12345678, 32'h0,   32'h0}};
        vecs[6]  = '{1, 0, 0, 32'h806, 32'h0,        32'h0,        0, '{0, 0, 0, 0, 0, 1, 0, 1'b0, 32'h11112222, 32'h12345678, 32'h0,   32'h0}};
        vecs[7]  = '{0, 1, 0, 32'h90C, 32'h0,        32'h0BADBEEF, 5, '{2, 0, 3, 0, 1, 0, 3, 1'b0, 32'h11112222, 32'h0BADBEEF, 32'h90C, 32'h0}};
        vecs[8]  = '{1, 1, 0, 32'h910, 32'h0,        32'h600DF00D, 0, '{2, 0, 3, 0, 1, 0, 3, 1'b0, 32'h11112222, 32'h600DF00D, 32'h910, 32'h0}};
        vecs[9]  = '{1, 0, 0, 32'h830, 32'h0,        32'hFFFFFFFF, 0, '{2, 0, 3, 1, 0, 0, 8, 1'b1, 32'hFFFFFFFF, 32'h600DF00D, 32'h830, 32'h0}};
        vecs[10] = '{1, 0, 0, 32'h800, 32'h0,        32'h82102000, 0, '{0, 0, 0, 0, 0, 0, 8, 1'b1, 32'hFFFFFFFF, 32'h600DF00D, 32'h0,   32'h0}};
        vecs[11] = '{0, 0, 1, 32'h904, 32'h55,       32'h0,        1, '{0, 0, 0, 0, 0, 0, 8, 1'b1, 32'hFFFFFFFF, 32'h600DF00D, 32'h0,   32'h0}};
        vecs[12] = '{0, 0, 1, 32'h802, 32'h55,       32'h0,        0, '{0, 0, 0, 0, 0, 0, 8, 1'b1, 32'hFFFFFFFF, 32'h600DF00D, 32'h0,   32'h0}};

        for (int i = 0; i < 13; i++) begin
            tb_mem[vecs[i].addr[9:2]] = vecs[i].memval;
            run_op(vecs[i].ifr, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_cyc);
            compare_obs($sformatf("vec%0d", i), vecs[i].e);
        end
        do_reset("reset_after_halt");

        // Arbitration: load and fetch raised together, load goes first
        tb_mem[8'h40] = 32'h12345678;   // 0x900
        tb_mem[8'h20] = 32'h01020304;   // 0x880
        if_req = 1'b1; pc = 32'h880; d_rd = 1'b1; daddr = 32'h900; d_wr = 1'b0;
        a1 = '0; a2 = '0; naddr = 0; dcyc = 0; icyc = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (mem_rd) begin
                if (naddr == 0) begin
                    a1 = mem_addr; naddr = 1;
                end else if (naddr == 1 && mem_addr != a1) begin
                    a2 = mem_addr; naddr = 2;
                end
            end
            if (d_done && dcyc == 0) begin
                dcyc = c; chk("arb_rdata", rdata, 32'h12345678); d_rd = 1'b0;
            end
            if (if_done && icyc == 0) begin
                icyc = c; chk("arb_ir", ir, 32'h01020304); if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_rd = 1'b0;
        chk("arb_first_addr", a1, 32'h900);
        chk("arb_second_addr", a2, 32'h880);
        chk("arb_d_done_cycle", dcyc, 3);
        chk("arb_if_done_cycle", icyc, 7);

        // Reset in the middle of a fetch ACCESS
        tb_mem[8'h10] = 32'h13572468;   // 0x840
        tb_mem[8'h11] = 32'h2468ACE0;   // 0x844
        run_op(1, 0, 0, 32'h840, 32'h0, 0);
        chk("rsta_pre_ir", ir, 32'h13572468);
        if_req = 1'b1; pc = 32'h844;
        @(negedge clk);
        chk("rsta_rd_in_access", mem_rd, 1'b1);
        rst = 1'b1;
        #1;
        chk("rsta_rd", mem_rd, 1'b0);
        chk("rsta_ir", ir, 32'h0);
        chk("rsta_busy", busy, 1'b0);
        chk("rsta_halt", halt, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_done || mem_rd) cnt++;
        end
        chk("rsta_no_late_done", cnt, 0);
        m_ir = '0; m_rdata = '0; m_halted = 1'b0;
        model_op(1, 0, 0, 32'h844, 32'h0, 32'h2468ACE0, 0, e);
        run_op(1, 0, 0, 32'h844, 32'h0, 0);
        compare_obs("rsta_refetch", e);

        // Random single operations against the reference model
        for (int n = 0; n < 80; n++) begin
            {ifr, rd, wr} = 3'($urandom_range(1, 7));
            addr = 32'h800 + {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wd   = $urandom;
            mv   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
            ackc = $urandom_range(0, 4);
            was_halted = m_halted;
            tb_mem[addr[9:2]] = mv;
            model_op(ifr, rd, wr, addr, wd, mv, ackc, e);
            run_op(ifr, rd, wr, addr, wd, ackc);
            compare_obs($sformatf("rnd%0d", n), e);
            if (was_halted) do_reset($sformatf("rnd%0d_reset", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_controller.md
# memory_access_controller

- Sequential front end that sits directly upstream of `MAIN_MEMORY` and is the only master driving it.
- Accepts instruction-fetch requests from the control unit and load/store requests from the datapath, and arbitrates between them.
- Drives the memory address, data, RD and WR lines, and completes each access on `ACK` or on a fixed-latency timeout.
- Returns the fetched instruction in a latched IR, and raises a sticky halt flag when the fetched word is the `halt` encoding `0xFFFFFFFF`.

## Interface
Parameters:
- `DATAWIDTH_BUS`, 32: width of address and data buses.
- `MEM_LATENCY`, 2: maximum ACCESS cycles before the access completes without `ACK`. Legal range 1..15.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `MEMCTRL_CLOCK_50`  in  1  system clock.
  - `MEMCTRL_RESET_InHigh`  in  1  asynchronous active-high reset.
- Instruction-fetch side:
  - `MEMCTRL_IF_REQ_In`  in  1  fetch request, level, held until DONE.
  - `MEMCTRL_IF_PC_InBUS`  in  32  fetch address.
  - `MEMCTRL_IF_IR_OutBUS`  out  32  last fetched instruction.
  - `MEMCTRL_IF_DONE_Out`  out  1  one-cycle fetch completion pulse.
- Data side:
  - `MEMCTRL_D_RD_In`  in  1  data read request, level.
  - `MEMCTRL_D_WR_In`  in  1  data write request, level.
  - `MEMCTRL_D_ADDRESS_InBUS`  in  32  data address.
  - `MEMCTRL_D_WDATA_InBUS`  in  32  store data.
  - `MEMCTRL_D_RDATA_OutBUS`  out  32  last load data.
  - `MEMCTRL_D_DONE_Out`  out  1  one-cycle data completion pulse.
- Status:
  - `MEMCTRL_BUSY_Out`  out  1  high in every state except IDLE.
  - `MEMCTRL_HALT_Out`  out  1  sticky halt flag.
  - `MEMCTRL_ALIGN_ERR_Out`  out  1  one-cycle pulse on a rejected misaligned request.
- Memory side:
  - `MEMCTRL_MEM_ADDRESS_OutBUS`  out  32  to memory address input.
  - `MEMCTRL_MEM_data_OutBUS`  out  32  to memory data input.
  - `MEMCTRL_MEM_RD_Out`  out  1  memory read strobe.
  - `MEMCTRL_MEM_WR_Out`  out  1  memory write strobe.
  - `MEMCTRL_MEM_data_InBUS`  in  32  memory read data, combinational.
  - `MEMCTRL_MEM_ACK_In`  in  1  memory acknowledge; may be left tied low.

## Operation
- **Reset values:** every output is 0, state is IDLE, the wait counter is 0.
- **States:**
  - **IDLE.**
    - Requests are sampled at each rising edge. Priority order: data write, then data read, then fetch.
    - If `D_RD` and `D_WR` are both high, the request is a write.
    - The selected address must have bits [1:0] = 0. Otherwise `ALIGN_ERR` pulses on the next cycle, no memory cycle is issued, and the state stays IDLE.
    - A valid request registers the memory address, data and the RD or WR strobe, and moves to ACCESS.
  - **ACCESS.**
    - Memory outputs are held stable. The counter counts ACCESS cycles starting at 1.
    - The access completes at the edge where `ACK`=1 or the counter equals `MEM_LATENCY`, whichever comes first.
    - At that edge: a read captures `MEM_data_InBUS` into IR (fetch) or RDATA (load). RD and WR are deasserted. The state moves to DONE.
  - **DONE.**
    - The matching DONE output is high for exactly this one cycle.
    - No request is sampled in this cycle, so requesters can drop their level requests.
    - If the captured fetch word is `0xFFFFFFFF`, `HALT` is set in this cycle and the next state is HALTED. Otherwise the next state is IDLE.
  - **HALTED.**
    - All requests are ignored and no DONE or ALIGN_ERR output is raised.
    - `BUSY`=1. Only reset leaves this state.
- **Data retention:**
  - IR and RDATA hold their values until the next completion of the same kind.
  - A write never changes IR or RDATA.
- **Counter width:** 4 bits. It resets to 0 on entry to DONE.

## Timing
- **Fetch latency:**
  - Request sampled at edge 0.
  - ACCESS runs from cycle 1 to cycle k, where k = first cycle with `ACK`, or `MEM_LATENCY`.
  - DONE is high in cycle k+1.
  - The next request is sampled no earlier than the edge ending cycle k+1.
- **Back-to-back accesses:** minimum period is `MEM_LATENCY`+2 cycles without ACK. With ACK in the first ACCESS cycle it is 3.
- **ACK outside ACCESS:** ignored.
- **Request drops during ACCESS:** the access still completes and DONE still pulses.
- **Reset during ACCESS or DONE:**
  - All outputs clear asynchronously, including strobes and DONE.
  - The state goes to IDLE and no completion is reported afterwards.
- **Data waiting during a fetch:** a data request arriving while a fetch is in ACCESS waits and is served first at the next IDLE sample.

## Structure
- **Package `memctrl_pkg`:**
  - state encoding IDLE/ACCESS/DONE/HALTED;
  - `HALT_OPCODE` = 32'hFFFFFFFF;
  - access-kind encoding FETCH/LOAD/STORE;
  - default `MEM_LATENCY`.
- **Sub-module `memctrl_latency_counter`:** 4-bit counter with clear, enable and terminal-count compare against `MEM_LATENCY`.
- Everything else stays in one always-block FSM plus registered outputs.

## Test plan
- **Fetch without ACK:**
  - Stimulus: `IF_REQ`=1, PC=0x800, memory returns 0x82102000, ACK tied low, `MEM_LATENCY`=2.
  - Response: `MEM_RD` high for cycles 1-2, IR=0x82102000 and IF_DONE=1 in cycle 3, `BUSY` low in cycle 4.
- **Early ACK:**
  - Stimulus: same fetch with ACK=1 in the first ACCESS cycle.
  - Response: IF_DONE in cycle 2, IR loaded, one `MEM_RD` cycle.
- **Arbitration:**
  - Stimulus: `IF_REQ` and `D_RD` (addr 0x900, data 0x12345678) raised in the same cycle.
  - Response: load served first (RDATA=0x12345678, D_DONE), then the fetch, with `MEM_ADDRESS`=0x900 before the PC.
- **Halt:**
  - Stimulus: fetch at 0x830 returning 0xFFFFFFFF.
  - Response: IF_DONE=1 and `HALT`=1 in the same cycle. A subsequent `IF_REQ` or `D_WR` produces no `MEM_RD`/`MEM_WR`, and `HALT` stays 1 until reset.
- **Misaligned request:**
  - Stimulus: `D_WR` at address 0x802.
  - Response: ALIGN_ERR pulse for one cycle, no `MEM_WR`, no D_DONE, state IDLE.
- **Reset during ACCESS:**
  - Stimulus: assert reset mid-ACCESS of a fetch.
  - Response: `MEM_RD`, IR, `BUSY` and `HALT` are 0 immediately, no IF_DONE after reset is released, and a new fetch then completes normally.
